// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the two-port memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D} state_e;
    localparam logic [31:0] MEM_ARB_ABORT_DATA = 32'hDEAD_BEEF;
    localparam int MEM_ARB_TIMEOUT_CYC = 64;
endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: counts bus cycles without an ack; expire_o flags the last allowed cycle.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: serialises IF and data requests onto one req/ack memory port with a timeout watchdog.
// Define MEM_ARB_FAIR_EN to let a waiting fetch win after two data grants in a row.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                err
);
    state_e state_q, state_d;
    logic m_req_q, m_req_d, m_we_q, m_we_d, if_ready_q, if_ready_d, d_ready_q, d_ready_d, err_q, err_d;
    logic [DATA_W/8-1:0] m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d, rsp;
    logic idle, in_bus, d_v, if_v, fair_pri, grant_if, grant_d, expire, done;

    assign idle     = state_q == IDLE;
    assign in_bus   = !idle;
    assign d_v      = d_req && !d_ready_q;
    assign if_v     = if_req && !if_ready_q;
    assign grant_if = idle && if_v && (!d_v || fair_pri);
    assign grant_d  = idle && d_v && !grant_if;
    // an ack in the expiry cycle still counts as a normal completion
    assign done     = in_bus && (m_ack || expire);
    assign rsp      = m_ack ? m_rdata : DATA_W'(MEM_ARB_ABORT_DATA);

`ifdef MEM_ARB_FAIR_EN
    logic [1:0] fcnt_q, fcnt_d;
    assign fcnt_d   = grant_if ? 2'd0 : (grant_d && if_req && fcnt_q != 2'd2) ? fcnt_q + 2'd1 : fcnt_q;
    assign fair_pri = fcnt_q == 2'd2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fcnt_q <= 2'd0;
        else fcnt_q <= fcnt_d;
    end
`else
    assign fair_pri = 1'b0;
`endif

    mem_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk(clk), .reset(reset), .clr_i(idle), .en_i(in_bus), .expire_o(expire)
    );

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_be_d     = m_be_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        err_d      = err_q;
        if (grant_if || grant_d) begin
            state_d   = grant_d ? BUS_D : BUS_IF;
            m_req_d   = 1'b1;
            m_we_d    = grant_d && d_we;
            m_be_d    = grant_d ? d_be : '0;
            m_addr_d  = grant_d ? d_addr : if_addr;
            m_wdata_d = grant_d ? d_wdata : '0;
        end else if (done) begin
            state_d    = IDLE;
            m_req_d    = 1'b0;
            err_d      = err_q || !m_ack;
            d_ready_d  = state_q == BUS_D;
            if_ready_d = state_q == BUS_IF;
            d_rdata_d  = state_q == BUS_D ? rsp : d_rdata_q;
            if_rdata_d = state_q == BUS_IF ? rsp : if_rdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_be_q     <= m_be_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            err_q      <= err_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ready = if_ready_q;
    assign d_ready  = d_ready_q;
    assign err      = err_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed stimulus with a completion scoreboard and a latency-programmable memory model.
module tb_mem_arb;
    logic clk = 1'b0, reset = 1'b1;
    logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata, if_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0] d_be = '0, m_be;
    logic if_ready, d_ready, m_req, m_we, err;

    mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .m_req(m_req), .m_we(m_we),
        .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic is_d; logic [31:0] data;} exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_fail = 0;
    int lat = 1, w = 0, cyc = 0, ng = 0;
    bit mem_en = 1'b1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory model: acks lat cycles into a request with fixed per-address contents
    initial begin
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            if (m_req && mem_en) begin
                w++;
                if (w == lat) begin
                    m_ack = 1'b1;
                    m_rdata = m_addr == 32'h0 ? 32'h00500093 : m_addr == 32'h10 ? 32'h1234 :
                              m_addr == 32'h20 ? 32'h55 : 32'h0BAD_0000;
                end
            end else w = 0;
        end
    end

    always @(negedge clk) begin
        if (if_ready || d_ready) begin
            if (sb.size() == 0) chk("unexpected_ready", 72'({if_ready, d_ready}), 72'(0));
            else begin
                e = sb.pop_front();
                chk("ready_port", 72'({if_ready, d_ready}), e.is_d ? 72'(2'b01) : 72'(2'b10));
                chk("rdata", 72'(e.is_d ? d_rdata : if_rdata), 72'(e.data));
            end
        end
    end

    // caller is at posedge+1 with the arbiter idle
    task automatic req(input bit is_d, input bit we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input int max, output int n);
        sb.push_back({is_d, exp});
        if (is_d) begin d_we = we; d_be = be; d_addr = a; d_wdata = wd; d_req = 1'b1; end
        else begin if_addr = a; if_req = 1'b1; end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(is_d ? d_ready : if_ready) && n < max);
        chk("wait_ready", 72'(is_d ? d_ready : if_ready), 72'(1));
        d_req = 1'b0;
        if_req = 1'b0;
        d_we = 1'b0;
    endtask

    initial begin
        logic [5:0] gbits, gexp;
        bit prev, stop;
        int dc, ic, bus;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 72'({m_req, m_we, m_be, if_ready, d_ready, err}), 72'(0));
        chk("reset_bus", 72'({m_addr, m_wdata}), 72'(0));
        chk("reset_rdata", 72'({if_rdata, d_rdata}), 72'(0));
        reset = 1'b0;

        mem_en = 1'b0;
        d_addr = 32'h10;
        d_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bus_d_active", 72'(m_req), 72'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mreq_drop", 72'({m_req, err}), 72'(0));
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_no_ready", 72'(d_ready), 72'(0));
        reset = 1'b0;
        mem_en = 1'b1;

        req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00500093, 10, cyc);
        chk("fetch_latency", 72'(cyc), 72'(2));
        @(posedge clk);
        #1;
        chk("fetch_pulse_one", 72'({if_ready, err}), 72'(0));

        sb.push_back({1'b1, 32'h1234});
        sb.push_back({1'b0, 32'h00500093});
        d_addr = 32'h10;
        if_addr = 32'h0;
        d_req = 1'b1;
        if_req = 1'b1;
        dc = -1;
        ic = -1;
        for (int c = 0; c < 20 && (d_req || if_req); c++) begin
            @(posedge clk);
            #1;
            if (d_ready) begin d_req = 1'b0; dc = c; end
            if (if_ready) begin if_req = 1'b0; ic = c; end
        end
        chk("simul_order", 72'({dc, ic}), {8'h0, 32'd1, 32'd3});

        lat = 4;
        bus = 0;
        sb.push_back({1'b1, 32'h55});
        d_we = 1'b1;
        d_be = 4'b0011;
        d_addr = 32'h20;
        d_wdata = 32'hAABBCCDD;
        d_req = 1'b1;
        for (int c = 0; c < 20 && d_req; c++) begin
            @(posedge clk);
            #1;
            if (m_req) begin
                bus++;
                chk("store_bus", 72'({m_we, m_be, m_addr, m_wdata}), 72'({1'b1, 4'b0011, 32'h20, 32'hAABBCCDD}));
            end
            if (d_ready) d_req = 1'b0;
        end
        chk("store_bus_cycles", 72'(bus), 72'(4));
        d_we = 1'b0;
        lat = 1;

        mem_en = 1'b0;
        req(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'hDEAD_BEEF, 100, cyc);
        chk("timeout_latency", 72'(cyc), 72'(65));
        chk("timeout_err", 72'(err), 72'(1));
        mem_en = 1'b1;
        @(posedge clk);
        #1;
        req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00500093, 10, cyc);
        req(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'h1234, 10, cyc);
        chk("err_sticky", 72'(err), 72'(1));
        @(posedge clk);
        #1;

        // fetch backs off while data completes, so only fairness can beat data priority
        d_we = 1'b0;
        d_addr = 32'h10;
        if_addr = 32'h0;
        d_req = 1'b1;
        if_req = 1'b1;
        prev = 1'b0;
        stop = 1'b0;
        gbits = '0;
        for (int c = 0; c < 80 && !stop; c++) begin
            @(posedge clk);
            #1;
            if (m_req && !prev && ng < 6) begin
                gbits[ng] = m_addr == 32'h10;
                sb.push_back(m_addr == 32'h10 ? {1'b1, 32'h1234} : {1'b0, 32'h00500093});
                ng++;
            end
            prev = m_req;
            if (ng == 6 && (d_ready || if_ready)) begin
                stop = 1'b1;
                d_req = 1'b0;
                if_req = 1'b0;
            end else if_req = !d_ready;
        end
        d_req = 1'b0;
        if_req = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        gexp = 6'b011011;
`else
        gexp = 6'b111111;
`endif
        chk("grant_count", 72'(ng), 72'(6));
        chk("grant_order", 72'(gbits), 72'(gexp));

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 72'(sb.size()), 72'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
